// File: rtl/tm_host_driver_if.sv
// Host-side bundle for tm_host_driver.
//   wr_valid/wr_data/wr_ready : symbol FIFO write handshake
//   start                     : one-cycle request to transmit the FIFO contents
//   busy                      : transmission or wait in progress
//   result/result_valid       : captured display value and its update pulse
//   timeout                   : sticky abort flag for the wait phase
// master = host side, slave = tm_host_driver.
interface tm_host_driver_if;
    logic        wr_valid;
    logic [5:0]  wr_data;
    logic        wr_ready;
    logic        start;
    logic        busy;
    logic [10:0] result;
    logic        result_valid;
    logic        timeout;

    modport master (
        output wr_valid, wr_data, start,
        input  wr_ready, busy, result, result_valid, timeout
    );

    modport slave (
        input  wr_valid, wr_data, start,
        output wr_ready, busy, result, result_valid, timeout
    );
endinterface

// File: rtl/tm_host_driver.sv
// Drives a tape-machine chip through its slow, synchronized pin interface.
// Symbols are queued in a FIFO by the host, then on start each symbol is
// presented on tm_data, strobed with tm_next (setup / pulse / gap, HOLD cycles
// each), followed by a tm_done pulse. The driver then waits for the chip's
// compute_done and captures its display value, or aborts after TIMEOUT cycles.
// Ports:
//   clock, reset_n         : clock and asynchronous active-low reset
//   host                   : host bundle (slave modport)
//   tm_data/tm_next/tm_done: registered pins to chip io_in[7:2]/[1]/[0]
//   tm_compute_done        : chip io_out[0], asynchronous
//   tm_display             : chip io_out[11:1], asynchronous
module tm_host_driver #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLD    = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                  clock,
    input  logic                  reset_n,
    tm_host_driver_if.slave       host,
    output logic [5:0]            tm_data,
    output logic                  tm_next,
    output logic                  tm_done,
    input  logic                  tm_compute_done,
    input  logic [10:0]           tm_display
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = $clog2(HOLD);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StDonePulse,
        StWait,
        StCapture
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Symbol FIFO: pointers carry one extra wrap bit so full and empty
    // are distinguishable without a separate count.
    // ------------------------------------------------------------------
    logic [5:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;
    logic [5:0]  head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    assign host.wr_ready = (state_q == StIdle) && !full;
    assign push          = host.wr_valid && host.wr_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= host.wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the chip's asynchronous outputs. The
    // display bus is only sampled once compute_done has been seen, by
    // which point the chip holds it stable.
    // ------------------------------------------------------------------
    logic        cd_meta_q, cd_sync_q;
    logic [10:0] disp_meta_q, disp_sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cd_meta_q   <= 1'b0;
            cd_sync_q   <= 1'b0;
            disp_meta_q <= '0;
            disp_sync_q <= '0;
        end else begin
            cd_meta_q   <= tm_compute_done;
            cd_sync_q   <= cd_meta_q;
            disp_meta_q <= tm_display;
            disp_sync_q <= disp_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          hold_last;
    logic          timeout_q, timeout_d;
    logic [10:0]   result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic [5:0]    tm_data_q, tm_data_d;
    logic          tm_next_q, tm_next_d;
    logic          tm_done_q, tm_done_d;

    assign hold_last = (hold_q == HW'(HOLD - 1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        pop       = 1'b0;

        case (state_q)
            StIdle: begin
                if (host.start) begin
                    timeout_d = 1'b0;
                    hold_d    = '0;
                    state_d   = empty ? StDonePulse : StSetup;
                end
            end
            StSetup: begin
                if (hold_last) begin
                    hold_d  = '0;
                    state_d = StPulse;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StPulse: begin
                if (hold_last) begin
                    hold_d  = '0;
                    pop     = 1'b1;
                    state_d = StGap;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StGap: begin
                // The pop at the end of the pulse has already advanced the
                // read pointer, so empty reflects the remaining symbols.
                if (hold_last) begin
                    hold_d  = '0;
                    state_d = empty ? StDonePulse : StSetup;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StDonePulse: begin
                if (hold_last) begin
                    hold_d  = '0;
                    wait_d  = '0;
                    state_d = StWait;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWait: begin
                // wait_q counts completed WAIT cycles; compute_done wins a tie
                // with the final timeout cycle.
                if (cd_sync_q) begin
                    state_d = StCapture;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pin and result registers are loaded from the next state so that each
    // pin changes on the same edge as the state it belongs to.
    always_comb begin
        tm_next_d      = (state_d == StPulse);
        tm_done_d      = (state_d == StDonePulse);
        result_valid_d = (state_d == StCapture);
        result_d       = (state_d == StCapture) ? disp_sync_q : result_q;

        case (state_d)
            StSetup:       tm_data_d = head;
            StPulse, StGap: tm_data_d = tm_data_q;
            default:       tm_data_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            hold_q         <= '0;
            wait_q         <= '0;
            timeout_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            tm_data_q      <= '0;
            tm_next_q      <= 1'b0;
            tm_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            wait_q         <= wait_d;
            timeout_q      <= timeout_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            tm_data_q      <= tm_data_d;
            tm_next_q      <= tm_next_d;
            tm_done_q      <= tm_done_d;
        end
    end

    assign tm_data           = tm_data_q;
    assign tm_next           = tm_next_q;
    assign tm_done           = tm_done_q;
    assign host.busy         = (state_q != StIdle);
    assign host.result       = result_q;
    assign host.result_valid = result_valid_q;
    assign host.timeout      = timeout_q;

endmodule

// File: tb/tb_tm_host_driver.sv
// Bench for tm_host_driver: a scoreboard queue of symbols written to the FIFO
// is compared against the symbol seen at each tm_next rising edge; a vector
// table drives whole transactions, and hand sequences cover exact pin timing,
// capture latency and reset during a pulse.
module tb_tm_host_driver;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned HOLD    = 4;
    localparam int unsigned TIMEOUT = 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  tm_data;
    logic        tm_next;
    logic        tm_done;
    logic        tm_compute_done;
    logic [10:0] tm_display;

    tm_host_driver_if host ();

    tm_host_driver #(
        .DEPTH   (DEPTH),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .host            (host),
        .tm_data         (tm_data),
        .tm_next         (tm_next),
        .tm_done         (tm_done),
        .tm_compute_done (tm_compute_done),
        .tm_display      (tm_display)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          nwr;
        logic [5:0]  base;
        int          exp_pulses;
        logic        cd;
        int          cd_delay;
        logic [10:0] disp;
    } vec_t;

    vec_t        vecs [5];
    int          errors = 0;
    int          checks = 0;
    logic [5:0]  exp_q [$];
    int          pulse_cnt = 0;
    int          rv_cnt = 0;
    int          model_count = 0;
    logic [10:0] last_result = '0;
    logic        next_prev = 1'b0;
    int          n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Chip-side monitor: every tm_next rising edge must carry the next
    // expected symbol.
    always @(negedge clock) begin
        if (reset_n) begin
            if (tm_next && !next_prev) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: tm_next pulse with data 0x%0h, required none",
                             tm_data);
                end else begin
                    check("pulse_symbol", tm_data, exp_q.pop_front());
                end
                check("next_done_exclusive", tm_done, 0);
            end
            if (host.result_valid) rv_cnt++;
            next_prev = tm_next;
        end else begin
            next_prev = 1'b0;
        end
    end

    task automatic write_sym(input logic [5:0] d);
        logic exp_rdy;
        @(negedge clock);
        exp_rdy = (model_count < int'(DEPTH));
        check("wr_ready", host.wr_ready, exp_rdy);
        host.wr_valid = 1'b1;
        host.wr_data  = d;
        @(negedge clock);
        host.wr_valid = 1'b0;
        if (exp_rdy) begin
            exp_q.push_back(d);
            model_count++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        host.start = 1'b1;
        @(negedge clock);
        host.start  = 1'b0;
        model_count = 0;
        check("start_busy", host.busy, 1);
        check("start_clears_timeout", host.timeout, 0);
    endtask

    // Write and start while busy: both must be ignored.
    task automatic poke_busy();
        @(negedge clock);
        check("busy_wr_ready", host.wr_ready, 0);
        host.wr_valid = 1'b1;
        host.wr_data  = 6'h3f;
        host.start    = 1'b1;
        @(negedge clock);
        host.wr_valid = 1'b0;
        host.start    = 1'b0;
    endtask

    task automatic wait_done_pulse(input int exp_pulses, output bit ok);
        int w = 0;
        int d = 0;
        while (!tm_done && w < 4000) begin
            @(negedge clock);
            w++;
        end
        if (!tm_done) begin
            checks++;
            errors++;
            $display("FAIL done_wait: tm_done=0 after %0d cycles, required a pulse", w);
            ok = 1'b0;
            return;
        end
        while (tm_done && d < 100) begin
            check("done_busy", host.busy, 1);
            check("done_data", tm_data, 0);
            @(negedge clock);
            d++;
        end
        check("done_len", d, HOLD);
        check("pulse_count", pulse_cnt, exp_pulses);
        check("scoreboard_empty", exp_q.size(), 0);
        check("wait_busy", host.busy, 1);
        ok = 1'b1;
    endtask

    // Called on the first WAIT cycle.
    task automatic finish_wait(input logic cd, input int delay, input logic [10:0] disp);
        int lat = 0;
        int w = 1;
        if (cd) begin
            repeat (delay - 1) @(negedge clock);
            tm_compute_done = 1'b1;
            tm_display      = disp;
            do begin
                @(negedge clock);
                lat++;
            end while (!host.result_valid && lat < 10);
            check("cap_latency", lat, 3);
            check("cap_result", host.result, disp);
            check("cap_busy", host.busy, 1);
            @(negedge clock);
            check("cap_rv_pulse", host.result_valid, 0);
            check("cap_idle", host.busy, 0);
            check("cap_rv_count", rv_cnt, 1);
            check("cap_no_timeout", host.timeout, 0);
            tm_compute_done = 1'b0;
            tm_display      = '0;
            last_result     = disp;
        end else begin
            while (host.busy && w < int'(TIMEOUT) + 10) begin
                @(negedge clock);
                if (host.busy) w++;
            end
            check("to_cycles", w, TIMEOUT);
            check("to_flag", host.timeout, 1);
            check("to_idle", host.busy, 0);
            check("to_result", host.result, last_result);
            check("to_rv_count", rv_cnt, 0);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit   ok;
        v = vecs[idx];
        pulse_cnt = 0;
        rv_cnt    = 0;
        for (int i = 0; i < v.nwr; i++) write_sym(v.base + 6'(i * 5));
        pulse_start();
        if (v.exp_pulses > 0) poke_busy();
        wait_done_pulse(v.exp_pulses, ok);
        if (ok) finish_wait(v.cd, v.cd_delay, v.disp);
    endtask

    initial begin
        host.wr_valid   = 1'b0;
        host.wr_data    = '0;
        host.start      = 1'b0;
        tm_compute_done = 1'b0;
        tm_display      = '0;
        reset_n         = 1'b0;

        vecs[0] = '{nwr: 3,  base: 6'h11, exp_pulses: 3,  cd: 1'b1, cd_delay: 5, disp: 11'h155};
        vecs[1] = '{nwr: 0,  base: 6'h00, exp_pulses: 0,  cd: 1'b1, cd_delay: 2, disp: 11'h2aa};
        vecs[2] = '{nwr: 17, base: 6'h20, exp_pulses: 16, cd: 1'b0, cd_delay: 0, disp: 11'h000};
        vecs[3] = '{nwr: 1,  base: 6'h3e, exp_pulses: 1,  cd: 1'b1, cd_delay: 1, disp: 11'h001};
        vecs[4] = '{nwr: 4,  base: 6'h07, exp_pulses: 4,  cd: 1'b1, cd_delay: 3, disp: 11'h7ff};

        #1;
        check("rst_tm_next", tm_next, 0);
        check("rst_tm_done", tm_done, 0);
        check("rst_tm_data", tm_data, 0);
        check("rst_busy", host.busy, 0);
        check("rst_result", host.result, 0);
        check("rst_result_valid", host.result_valid, 0);
        check("rst_timeout", host.timeout, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_wr_ready", host.wr_ready, 1);

        // Exact pin timing for two symbols, then capture 10 cycles into WAIT.
        write_sym(6'h05);
        write_sym(6'h2a);
        pulse_cnt = 0;
        rv_cnt    = 0;
        @(negedge clock);
        host.start = 1'b1;
        @(negedge clock);
        host.start  = 1'b0;
        model_count = 0;
        for (int c = 0; c < 24; c++) begin
            n = c % 12;
            check("seq_data", tm_data, (c < 12) ? 6'h05 : 6'h2a);
            check("seq_next", tm_next, (n >= 4 && n < 8));
            check("seq_done", tm_done, 0);
            check("seq_busy", host.busy, 1);
            @(negedge clock);
        end
        for (int c = 0; c < 4; c++) begin
            check("seq_done_hi", tm_done, 1);
            check("seq_done_data", tm_data, 0);
            check("seq_done_next", tm_next, 0);
            @(negedge clock);
        end
        check("seq_wait_done", tm_done, 0);
        check("seq_wait_busy", host.busy, 1);
        check("seq_pulses", pulse_cnt, 2);
        finish_wait(1'b1, 10, 11'h3ff);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset in the middle of a tm_next pulse.
        for (int i = 0; i < 3; i++) write_sym(6'h09 + 6'(i));
        pulse_start();
        n = 0;
        while (!tm_next && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("rst_reached_pulse", tm_next, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_tm_next", tm_next, 0);
        check("mid_rst_tm_done", tm_done, 0);
        check("mid_rst_tm_data", tm_data, 0);
        check("mid_rst_busy", host.busy, 0);
        exp_q.delete();
        model_count = 0;
        last_result = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_wr_ready", host.wr_ready, 1);
        check("post_rst_result", host.result, 0);
        check("post_rst_timeout", host.timeout, 0);
        run_vec(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
